pe_seq_ctrl: RTL and testbench

Sequencer and accumulator for one `pe` instance (MFU_COUNT multipliers sharing one activation per cycle). It accepts a job of `cfg_len` reduction steps and joins an activation stream with a weight-vector stream, one beat per step. It drives the registered PE inputs and accumulates the MFU_COUNT signed 16-bit products into saturating accumulators. It returns the MFU_COUNT dot products through a valid/ready result port. It sits between the activation/weight buffers and the output/writeback stage of the array.

---
 rtl/pe_seq_pkg.sv | 40 ++++
 rtl/pe_seq_ctrl_if.sv | 29 ++
 rtl/pe_acc_lane.sv | 33 +++
 rtl/pe_seq_ctrl.sv | 94 +++++++++
 tb/tb_pe_seq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_seq_pkg.sv
// Shared types and saturating arithmetic for the PE sequencer.
// Accumulator math is done at 64 bits, so any ACC_W up to 62 is safe.
package pe_seq_pkg;

  localparam int ACC_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic signed [63:0] acc_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] acc_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic logic signed [63:0] sat_add(input logic signed [63:0] acc,
                                                 input logic signed [15:0] prod,
                                                 input int w);
    logic signed [63:0] sum;
    sum = acc + 64'(prod);
    if (sum > acc_max(w)) return acc_max(w);
    if (sum < acc_min(w)) return acc_min(w);
    return sum;
  endfunction

  function automatic logic sat_ovf(input logic signed [63:0] acc,
                                   input logic signed [15:0] prod,
                                   input int w);
    logic signed [63:0] sum;
    sum = acc + 64'(prod);
    return (sum > acc_max(w)) || (sum < acc_min(w));
  endfunction

endpackage

// File: rtl/pe_seq_ctrl_if.sv
// Job, stream and result handshakes of the PE sequencer.
interface pe_seq_ctrl_if #(
  parameter int MFU_COUNT = 4,
  parameter int ACC_W     = 32,
  parameter int LEN_W     = 8
);
  logic                       start_valid;
  logic                       start_ready;
  logic [LEN_W-1:0]           cfg_len;
  logic                       act_valid;
  logic                       act_ready;
  logic [7:0]                 act_data;
  logic                       wgt_valid;
  logic                       wgt_ready;
  logic [MFU_COUNT*8-1:0]     wgt_data;
  logic                       res_valid;
  logic                       res_ready;
  logic [MFU_COUNT*ACC_W-1:0] res_data;

  modport master (
    output start_valid, cfg_len, act_valid, act_data, wgt_valid, wgt_data, res_ready,
    input  start_ready, act_ready, wgt_ready, res_valid, res_data
  );

  modport slave (
    input  start_valid, cfg_len, act_valid, act_data, wgt_valid, wgt_data, res_ready,
    output start_ready, act_ready, wgt_ready, res_valid, res_data
  );
endinterface

// File: rtl/pe_acc_lane.sv
// One saturating accumulator lane; once clamped it holds until the next clear.
module pe_acc_lane
  import pe_seq_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [15:0]      prod,
  output logic signed [ACC_W-1:0] acc
);

  logic               sat_q;
  logic signed [63:0] acc_ext;

  assign acc_ext = {{(64 - ACC_W){acc[ACC_W-1]}}, acc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      sat_q <= 1'b0;
    end else if (clr) begin
      acc   <= '0;
      sat_q <= 1'b0;
    end else if (en && !sat_q) begin
      acc   <= ACC_W'(sat_add(acc_ext, prod, ACC_W));
      sat_q <= sat_ovf(acc_ext, prod, ACC_W);
    end
  end

endmodule

// File: rtl/pe_seq_ctrl.sv
// Job sequencer for one PE: joins activation/weight beats, issues them to the PE
// and accumulates the returned products into per-lane saturating accumulators.
//
//   state | meaning
//   IDLE  | waiting for a start handshake
//   RUN   | consuming joined act/wgt beats until cfg_len are taken
//   DRAIN | last issued product is being accumulated
//   DONE  | result presented until res_ready
module pe_seq_ctrl
  import pe_seq_pkg::*;
#(
  parameter int MFU_COUNT = 4,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int LEN_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pe_seq_ctrl_if.slave           bus,
  output logic [7:0]             pe_a,
  output logic [MFU_COUNT*8-1:0] pe_w,
  input  logic [MFU_COUNT*16-1:0] pe_o,
  output logic                   busy
);

  state_e                     state_q, state_d;
  logic [LEN_W-1:0]           len_q;
  logic [LEN_W-1:0]           cnt_q;
  logic                       issue_q;
  logic                       start_fire;
  logic                       beat;
  logic [MFU_COUNT*ACC_W-1:0] res_flat;

  assign start_fire = (state_q == IDLE) && bus.start_valid;
  // Joined handshake: neither stream moves unless both are offering.
  assign beat       = (state_q == RUN) && bus.act_valid && bus.wgt_valid;

  assign bus.start_ready = (state_q == IDLE);
  assign bus.act_ready   = beat;
  assign bus.wgt_ready   = beat;
  assign bus.res_valid   = (state_q == DONE);
  assign bus.res_data    = res_flat;
  assign busy            = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_valid) state_d = (bus.cfg_len == '0) ? DONE : RUN;
      RUN:     if (beat && (cnt_q + LEN_W'(1) == len_q)) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      issue_q <= 1'b0;
      pe_a    <= '0;
      pe_w    <= '0;
    end else begin
      state_q <= state_d;
      issue_q <= beat;
      if (start_fire) begin
        len_q <= bus.cfg_len;
        cnt_q <= '0;
      end else if (beat) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
      if (beat) begin
        pe_a <= bus.act_data;
        pe_w <= bus.wgt_data;
      end
    end
  end

  for (genvar g = 0; g < MFU_COUNT; g++) begin : g_lane
    logic signed [ACC_W-1:0] acc;

    pe_acc_lane #(.ACC_W(ACC_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start_fire),
      .en    (issue_q),
      .prod  (pe_o[g*16 +: 16]),
      .acc   (acc)
    );

    assign res_flat[g*ACC_W +: ACC_W] = acc;
  end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl with a behavioural PE (signed 8x8 products).
module tb_pe_seq_ctrl;
  localparam int MFU = 4;
  localparam int AW  = 17;
  localparam int LW  = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       pe_a;
  logic [MFU*8-1:0] pe_w;
  logic [MFU*16-1:0] pe_o;
  logic             busy;

  int tests_run = 0;
  int tests_failed = 0;

  pe_seq_ctrl_if #(.MFU_COUNT(MFU), .ACC_W(AW), .LEN_W(LW)) bus ();

  pe_seq_ctrl #(.MFU_COUNT(MFU), .ACC_W(AW), .LEN_W(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .pe_a  (pe_a),
    .pe_w  (pe_w),
    .pe_o  (pe_o),
    .busy  (busy)
  );

  for (genvar g = 0; g < MFU; g++) begin : g_pe
    assign pe_o[g*16 +: 16] = 16'($signed(pe_a) * $signed(pe_w[g*8 +: 8]));
  end

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] lane(input int i);
    return bus.res_data[i*AW +: AW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one job from IDLE; beats are offered per stall pattern bit (cycle % 16).
  // Returns the cycle (start handshake = 0) at which res_valid was seen.
  task automatic run_job(input int len, input logic [63:0] acts, input logic [255:0] wgts,
                         input logic [15:0] av_pat, input logic [15:0] wv_pat,
                         output int cyc, output int ready_err);
    int  idx;
    logic av, wv, exp_rdy;
    idx = 0;
    ready_err = 0;
    bus.start_valid = 1'b1;
    bus.cfg_len = LW'(len);
    bus.act_valid = 1'b0;
    bus.wgt_valid = 1'b0;
    step();
    bus.start_valid = 1'b0;
    cyc = 1;
    while (bus.res_valid !== 1'b1 && cyc < 200) begin
      av = (idx < len) && av_pat[cyc % 16];
      wv = (idx < len) && wv_pat[cyc % 16];
      bus.act_valid = av;
      bus.wgt_valid = wv;
      bus.act_data = av ? acts[(idx % 8)*8 +: 8] : 8'h7F;
      bus.wgt_data = wv ? wgts[(idx % 8)*32 +: 32] : 32'h7F7F7F7F;
      #1;
      exp_rdy = av && wv;
      if (bus.act_ready !== exp_rdy || bus.wgt_ready !== exp_rdy) ready_err++;
      if (exp_rdy) idx++;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.act_valid = 1'b0;
    bus.wgt_valid = 1'b0;
  endtask

  task automatic take_result();
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if (bus.res_valid !== 1'b0 || busy !== 1'b0 || bus.act_ready !== 1'b0 || bus.wgt_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: res_valid=%b busy=%b act_ready=%b wgt_ready=%b, want all 0",
               bus.res_valid, busy, bus.act_ready, bus.wgt_ready);
    end
    tests_run++;
    if (pe_a !== 8'h0 || pe_w !== '0 || bus.res_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: pe_a=%h pe_w=%h res_data=%h, want 0", pe_a, pe_w, bus.res_data);
    end
    step();
    rst_n = 1'b1;
    step();
    tests_run++;
    if (bus.start_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_start_ready: got %b want 1", bus.start_ready);
    end
  endtask

  task automatic test_dot_product();
    int cyc, rerr;
    int exp [4] = '{6, 12, -6, -5};
    run_job(3, 64'h030201, {160'h0, 32'hFBFF0201, 32'h05FF0201, 32'h00FF0201},
            16'hFFFF, 16'hFFFF, cyc, rerr);
    tests_run++;
    if (cyc !== 5 || rerr !== 0) begin
      tests_failed++;
      $display("FAIL dot_timing: res_valid cycle=%0d ready_err=%0d, want 5 and 0", cyc, rerr);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (lane(i) !== AW'(exp[i])) begin
        tests_failed++;
        $display("FAIL dot_lane%0d: got %0d want %0d", i, $signed(lane(i)), exp[i]);
      end
    end
    take_result();
  endtask

  task automatic test_stalls();
    int cyc, rerr;
    logic [MFU*AW-1:0] stalled;
    logic [255:0] w;
    int exp [4] = '{10, -12, 10, 300};
    w = {128'h0, 32'h2802FB01, 32'h1E010401, 32'h1400FD01, 32'h0AFF0201};
    run_job(4, 64'h04030201, w, 16'hAAAA, 16'hCCCC, cyc, rerr);
    stalled = bus.res_data;
    tests_run++;
    if (cyc !== 17 || rerr !== 0) begin
      tests_failed++;
      $display("FAIL stall_timing: res_valid cycle=%0d ready_err=%0d, want 17 and 0", cyc, rerr);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (lane(i) !== AW'(exp[i])) begin
        tests_failed++;
        $display("FAIL stall_lane%0d: got %0d want %0d", i, $signed(lane(i)), exp[i]);
      end
    end
    take_result();
    run_job(4, 64'h04030201, w, 16'hFFFF, 16'hFFFF, cyc, rerr);
    tests_run++;
    if (bus.res_data !== stalled || cyc !== 6) begin
      tests_failed++;
      $display("FAIL stall_vs_unstalled: got %h (cycle %0d) want %h (cycle 6)",
               bus.res_data, cyc, stalled);
    end
    take_result();
  endtask

  task automatic test_saturation();
    int cyc, rerr;
    run_job(8, {8{8'h80}}, {8{32'h80808080}}, 16'hFFFF, 16'hFFFF, cyc, rerr);
    tests_run++;
    if (cyc !== 10 || bus.res_data !== {4{17'h0FFFF}}) begin
      tests_failed++;
      $display("FAIL sat_pos: got %h (cycle %0d) want lanes 0ffff (cycle 10)", bus.res_data, cyc);
    end
    take_result();
    run_job(8, {8{8'h80}}, {8{32'h7F7F7F7F}}, 16'hFFFF, 16'hFFFF, cyc, rerr);
    tests_run++;
    if (bus.res_data !== {4{17'h10000}}) begin
      tests_failed++;
      $display("FAIL sat_neg: got %h want lanes 10000 (-65536)", bus.res_data);
    end
    take_result();
  endtask

  task automatic test_zero_len();
    int cyc, rerr;
    run_job(0, 64'h0, 256'h0, 16'hFFFF, 16'hFFFF, cyc, rerr);
    tests_run++;
    if (cyc !== 1 || bus.res_data !== '0) begin
      tests_failed++;
      $display("FAIL zero_len: cycle=%0d data=%h, want cycle 1 data 0", cyc, bus.res_data);
    end
    bus.act_valid = 1'b1;
    bus.wgt_valid = 1'b1;
    #1;
    tests_run++;
    if (bus.act_ready !== 1'b0 || bus.wgt_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_len_streams: act_ready=%b wgt_ready=%b want 0", bus.act_ready, bus.wgt_ready);
    end
    bus.act_valid = 1'b0;
    bus.wgt_valid = 1'b0;
    take_result();
  endtask

  task automatic test_backpressure();
    int cyc, rerr;
    int bad = 0;
    run_job(1, 64'h02, {224'h0, 32'h04030201}, 16'hFFFF, 16'hFFFF, cyc, rerr);
    bus.act_valid = 1'b1;
    bus.wgt_valid = 1'b1;
    bus.start_valid = 1'b1;
    bus.cfg_len = 8'd2;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (bus.res_valid !== 1'b1 || bus.res_data !== {17'd8, 17'd6, 17'd4, 17'd2} ||
          bus.start_ready !== 1'b0 || bus.act_ready !== 1'b0 || bus.wgt_ready !== 1'b0) bad++;
      step();
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL bp_hold: %0d of 5 cycles unstable, want 0 (data=%h)", bad, bus.res_data);
    end
    bus.act_valid = 1'b0;
    bus.wgt_valid = 1'b0;
    bus.start_valid = 1'b0;
    take_result();
    tests_run++;
    if (bus.res_valid !== 1'b0 || bus.start_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: res_valid=%b start_ready=%b busy=%b want 0 1 0",
               bus.res_valid, bus.start_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, rerr;
    run_job(1, 64'h05, {224'h0, 32'h01010101}, 16'hFFFF, 16'hFFFF, cyc, rerr);
    take_result();
    run_job(2, 64'h0101, {192'h0, 32'h01010101, 32'h01010101}, 16'hFFFF, 16'hFFFF, cyc, rerr);
    tests_run++;
    if (cyc !== 4 || bus.res_data !== {4{17'd2}}) begin
      tests_failed++;
      $display("FAIL b2b_clear: got %h (cycle %0d) want lanes 2 (cycle 4)", bus.res_data, cyc);
    end
    take_result();
  endtask

  task automatic test_reset_mid_job();
    int cyc, rerr;
    bus.start_valid = 1'b1;
    bus.cfg_len = 8'd4;
    step();
    bus.start_valid = 1'b0;
    bus.act_valid = 1'b1;
    bus.wgt_valid = 1'b1;
    bus.act_data = 8'd7;
    bus.wgt_data = 32'h09090909;
    step();
    step();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.act_ready !== 1'b0 || pe_a !== 8'h0 ||
        pe_w !== '0 || bus.res_data !== '0) begin
      tests_failed++;
      $display("FAIL midrst_outputs: busy=%b res_valid=%b act_ready=%b pe_a=%h pe_w=%h data=%h want 0",
               busy, bus.res_valid, bus.act_ready, pe_a, pe_w, bus.res_data);
    end
    bus.act_valid = 1'b0;
    bus.wgt_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    run_job(1, 64'h03, {224'h0, 32'h02020202}, 16'hFFFF, 16'hFFFF, cyc, rerr);
    tests_run++;
    if (cyc !== 3 || bus.res_data !== {4{17'd6}}) begin
      tests_failed++;
      $display("FAIL midrst_next_job: got %h (cycle %0d) want lanes 6 (cycle 3)", bus.res_data, cyc);
    end
    take_result();
  endtask

  initial begin
    bus.start_valid = 1'b0;
    bus.cfg_len = '0;
    bus.act_valid = 1'b0;
    bus.act_data = '0;
    bus.wgt_valid = 1'b0;
    bus.wgt_data = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_dot_product();
    test_stalls();
    test_saturation();
    test_zero_len();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_job();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
